fetch_redirect_ctrl: RTL and testbench

//  Fetch-side consumer of the EX-stage branch comparator's (success, new_address) redirect.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 12 +
 rtl/fetch_redirect_ctrl_if.sv | 15 +
 rtl/fetch_redirect_ctrl_hold_buf.sv | 41 ++++
 rtl/fetch_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared fetch-pipeline definitions: FSM state type and default PC parameters.
package fetch_redirect_ctrl_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-memory req/ack bus.
//   req   : fetch request, held until ack
//   addr  : fetch address, stable while req=1
//   ack   : rdata valid this cycle
//   rdata : fetched instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_redirect_ctrl_if #(parameter int XLEN = 32);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_redirect_ctrl_hold_buf.sv
// fetch_hold_buf: 1-entry valid/pc/instr register feeding IF/ID.
//   i_load        : capture i_pc/i_instr, set valid
//   i_clr         : drop entry (valid, pc, instr -> 0); wins over i_load
//   neither       : hold contents (decode stall)
//   o_valid/o_pc/o_instr : registered entry
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_load,
  input  logic            i_clr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_instr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the architectural PC, runs the imem req/ack
// handshake, applies EX-stage redirects and holds fetched words under stall.
//   i_clk, i_reset_n        : clock, async active-low reset
//   i_br_success/i_br_target: redirect from EX (priority over stall/ack)
//   i_stall                 : IF/ID cannot accept
//   imem                    : instruction memory bus (master side)
//   o_if_valid/pc/instr     : word delivered to IF/ID
//   o_flush                 : combinational copy of i_br_success
//   o_misalign_err          : sticky, a redirect target had bits [1:0] != 0
//   o_taken_cnt             : accepted redirects, wrapping
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32,
  parameter int          PC_STEP  = fetch_redirect_ctrl_pkg::PC_STEP
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_br_success,
  input  logic [XLEN-1:0]       i_br_target,
  input  logic                  i_stall,
  fetch_redirect_ctrl_if.master imem,
  output logic                  o_if_valid,
  output logic [XLEN-1:0]       o_if_pc,
  output logic [XLEN-1:0]       o_if_instr,
  output logic                  o_flush,
  output logic                  o_misalign_err,
  output logic [XLEN-1:0]       o_taken_cnt
);
  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;    // doubles as imem.addr; stays on the old address in DISCARD
  logic [XLEN-1:0] r_tgt;   // redirect target parked while the wrong-path ack is pending
  logic            r_req;
  logic            r_mis;
  logic [XLEN-1:0] r_cnt;

  logic [XLEN-1:0] w_tgt, w_pc_nxt;
  logic            w_br, w_ack, w_load, w_clr;

  assign w_br     = i_br_success;
  assign w_ack    = imem.ack;
  assign w_tgt    = {i_br_target[XLEN-1:2], 2'b00};
  assign w_pc_nxt = r_pc + XLEN'(PC_STEP);

  // Only a right-path ack in FETCH delivers a word; a redirect drops it.
  // Without a new word, the entry survives only while decode is stalled.
  assign w_load = (r_state == FETCH) && w_ack && !w_br;
  assign w_clr  = w_br || (!w_load && !i_stall);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= BOOT;
      r_pc    <= XLEN'(RESET_PC);
      r_tgt   <= XLEN'(RESET_PC);
      r_req   <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_br) begin
        r_cnt <= r_cnt + XLEN'(1);
        if (|i_br_target[1:0]) r_mis <= 1'b1;
      end
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          if (w_br) r_pc <= w_tgt;
        end
        FETCH: begin
          if (w_br) begin
            // Request still open: imem.addr must not move, so park the target.
            if (w_ack) r_pc <= w_tgt;
            else begin
              r_tgt   <= w_tgt;
              r_state <= DISCARD;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_nxt;
            if (i_stall) begin
              r_state <= HOLD;
              r_req   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (w_br || !i_stall) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            if (w_br) r_pc <= w_tgt;
          end
        end
        DISCARD: begin
          if (w_ack) begin
            r_state <= FETCH;
            r_pc    <= w_br ? w_tgt : r_tgt;
          end else if (w_br) begin
            r_tgt <= w_tgt;   // last redirect wins
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (w_load),
    .i_clr    (w_clr),
    .i_pc     (r_pc),
    .i_instr  (imem.rdata),
    .o_valid  (o_if_valid),
    .o_pc     (o_if_pc),
    .o_instr  (o_if_instr)
  );

  assign imem.req       = r_req;
  assign imem.addr      = r_pc;
  assign o_flush        = w_br;
  assign o_misalign_err = r_mis;
  assign o_taken_cnt    = r_cnt;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;
  logic        gclk = 1'b0;
  logic        reset_n;
  logic        br, stall;
  logic [31:0] tgt;
  logic        if_valid, flush, mis;
  logic [31:0] if_pc, if_instr, cnt;

  always #5 gclk = ~gclk;

  fetch_redirect_ctrl_if #(.XLEN(32)) imem ();

  fetch_redirect_ctrl #(.RESET_PC(32'h0), .XLEN(32), .PC_STEP(4)) dut (
    .i_clk         (gclk),
    .i_reset_n     (reset_n),
    .i_br_success  (br),
    .i_br_target   (tgt),
    .i_stall       (stall),
    .imem          (imem),
    .o_if_valid    (if_valid),
    .o_if_pc       (if_pc),
    .o_if_instr    (if_instr),
    .o_flush       (flush),
    .o_misalign_err(mis),
    .o_taken_cnt   (cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Reference model: "is a request open", "is the open request wrong-path",
  // "are we in the post-reset idle cycle", plus the delivered word.
  bit          m_boot, m_req, m_stale, m_vld, m_mis;
  logic [31:0] m_pc, m_tgt, m_ipc, m_instr, m_cnt;

  task automatic m_reset();
    m_boot = 1; m_req = 0; m_stale = 0; m_vld = 0; m_mis = 0;
    m_pc = 0; m_tgt = 0; m_ipc = 0; m_instr = 0; m_cnt = 0;
  endtask

  task automatic m_drop();
    m_vld = 0; m_ipc = 0; m_instr = 0;
  endtask

  task automatic m_step(input bit b, input logic [31:0] t, input bit st,
                        input bit a, input logic [31:0] rd);
    bit acc;
    acc = m_req && a;
    if (b) begin
      m_cnt = m_cnt + 1;
      if (t[1:0] != 2'b00) m_mis = 1;
      m_drop();
      m_boot = 0;
      if (m_req && !acc) begin
        m_stale = 1;
        m_tgt   = t & 32'hFFFF_FFFC;
      end else begin
        m_stale = 0;
        m_pc    = t & 32'hFFFF_FFFC;
        m_req   = 1;
      end
    end else if (m_boot) begin
      m_boot = 0;
      m_req  = 1;
    end else if (acc && m_stale) begin
      m_stale = 0;
      m_pc    = m_tgt;
      m_drop();
    end else if (acc) begin
      m_vld   = 1;
      m_ipc   = m_pc;
      m_instr = rd;
      m_pc    = m_pc + 4;
      m_req   = !st;
    end else if (!st) begin
      m_drop();
      m_req = 1;
    end
  endtask

  task automatic check_all();
    chk("req",      imem.req,  m_req);
    chk("addr",     imem.addr, m_pc);
    chk("if_valid", if_valid,  m_vld);
    chk("if_pc",    if_pc,     m_ipc);
    chk("if_instr", if_instr,  m_instr);
    chk("flush",    flush,     br);
    chk("mis",      mis,       m_mis);
    chk("cnt",      cnt,       m_cnt);
  endtask

  // Starts and ends at a negedge.
  task automatic cycle(input bit b, input logic [31:0] t, input bit st,
                       input bit a, input logic [31:0] rd);
    br = b; tgt = t; stall = st; imem.ack = a; imem.rdata = rd;
    #1 check_all();
    @(posedge gclk);
    m_step(b, t, st, a, rd);
    @(negedge gclk);
  endtask

  task automatic do_reset();
    br = 0; tgt = 0; stall = 0; imem.ack = 0; imem.rdata = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_req",   imem.req,  32'd0);
    chk("rst_addr",  imem.addr, 32'd0);
    chk("rst_valid", if_valid,  32'd0);
    chk("rst_pc",    if_pc,     32'd0);
    chk("rst_instr", if_instr,  32'd0);
    chk("rst_mis",   mis,       32'd0);
    chk("rst_cnt",   cnt,       32'd0);
    m_reset();
    @(negedge gclk);
    @(negedge gclk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    @(negedge gclk);
    do_reset();

    // 1: straight-line fetch, ack every cycle
    cycle(0, 0, 0, 0, 0);                       // BOOT
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'hA000_0000 + i);
    chk("t1_addr",  imem.addr, 32'd16);
    chk("t1_if_pc", if_pc,     32'd12);
    chk("t1_cnt",   cnt,       32'd0);

    // 2: redirect to 0x40 while ack withheld, then the stale ack
    cycle(1, 32'h40, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t2_addr_held", imem.addr, 32'd16);
    cycle(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t2_drop",  if_valid,  32'd0);
    chk("t2_addr",  imem.addr, 32'h40);
    chk("t2_cnt",   cnt,       32'd1);

    // 3: redirect coincident with ack
    cycle(1, 32'h100, 0, 1, 32'h1234_5678);
    chk("t3_drop", if_valid,  32'd0);
    chk("t3_addr", imem.addr, 32'h100);

    // 4: stall at ack of 0x8
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h11);
    cycle(0, 0, 0, 1, 32'h22);
    cycle(0, 0, 1, 1, 32'h33);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 32'hBAD0 + i);
    chk("t4_pc",    if_pc,    32'h8);
    chk("t4_instr", if_instr, 32'h33);
    chk("t4_req",   imem.req, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("t4_addr",  imem.addr, 32'hC);

    // 5: misaligned target, then PC wrap
    cycle(1, 32'h203, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0);
    chk("t5_mis",  mis,       32'd1);
    chk("t5_addr", imem.addr, 32'h200);
    cycle(1, 32'hFFFF_FFFC, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h55);
    chk("t5_wrap", imem.addr, 32'h0);

    // 6: reset during DISCARD
    cycle(1, 32'h80, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk("t6_req",  imem.req,  32'd1);
    chk("t6_addr", imem.addr, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
      else if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      cycle($urandom_range(0, 7) == 0, t, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 6, $urandom);
      if (i == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
